// File: rtl/mi_arbiter_pkg.sv
// Shared types for the memory-interface arbiter: FSM state encoding and data width.
package mi_arbiter_pkg;

  localparam int DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/mi_arbiter_rr_pick.sv
// Rotate-priority picker: one-hot winner is the first valid index after the last winner.
// Purely combinational, zero latency; no flow control of its own.
module mi_arb_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] valid,
  input  logic [N-1:0] last,
  output logic [N-1:0] win
);

  always_comb begin
    int   base;
    logic found;
    base  = N - 1;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      if (last[i]) base = i;
    end
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && (i == (base + k) % N) && valid[i]) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mi_arbiter.sv
// Round-robin arbiter sharing one memctrl mi_* port among N_REQ burst requesters; MI_ARB_FIXED_PRIO_EN gives requester 0 absolute priority.
// Latency: grant registered, mi_valid one cycle after req_valid; one dead IDLE cycle between bursts.
// Backpressure: command waits on mi_ready; grant held until the last data beat, no pre-emption.
module mi_arbiter
  import mi_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = 24,
  parameter int LW    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*LW-1:0] req_len,
  input  logic [N_REQ-1:0]    req_rw,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_wack,
  output logic [N_REQ-1:0]    req_wlast,
  output logic [DW-1:0]       req_rdata,
  output logic [N_REQ-1:0]    req_rstb,
  output logic [N_REQ-1:0]    req_rlast,
  output logic [AW-1:0]       mi_addr,
  output logic [LW-1:0]       mi_len,
  output logic                mi_rw,
  output logic                mi_valid,
  input  logic                mi_ready,
  output logic [DW-1:0]       mi_wdata,
  input  logic                mi_wack,
  input  logic                mi_wlast,
  input  logic                mi_rstb,
  input  logic                mi_rlast,
  input  logic [DW-1:0]       mi_rdata,
  output logic [N_REQ-1:0]    grant
);

  state_t           state;
  logic [N_REQ-1:0] last_win;
  logic             rw_q;
  logic [N_REQ-1:0] pick_valid;
  logic [N_REQ-1:0] pick_win;
  logic [N_REQ-1:0] win;

  logic             own_valid;
  logic [AW-1:0]    own_addr;
  logic [LW-1:0]    own_len;
  logic             own_rw;
  logic [DW-1:0]    own_wdata;
  logic             in_cmd;
  logic             in_data;
  logic             burst_end;

  // Requester 0 is taken out of the rotation when it has absolute priority.
`ifdef MI_ARB_FIXED_PRIO_EN
  assign pick_valid = {req_valid[N_REQ-1:1], 1'b0};
  assign win        = req_valid[0] ? N_REQ'(1) : pick_win;
`else
  assign pick_valid = req_valid;
  assign win        = pick_win;
`endif

  mi_arb_rr_pick #(.N(N_REQ)) u_pick (
    .valid (pick_valid),
    .last  (last_win),
    .win   (pick_win)
  );

  always_comb begin
    own_valid = 1'b0;
    own_addr  = '0;
    own_len   = '0;
    own_rw    = 1'b0;
    own_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        own_valid = own_valid | req_valid[i];
        own_addr  = own_addr  | req_addr[i*AW +: AW];
        own_len   = own_len   | req_len[i*LW +: LW];
        own_rw    = own_rw    | req_rw[i];
        own_wdata = own_wdata | req_wdata[i*DW +: DW];
      end
    end
  end

  assign in_cmd  = (state == ST_CMD);
  assign in_data = (state == ST_DATA);

  assign mi_valid  = in_cmd & own_valid;
  assign mi_addr   = in_cmd ? own_addr : '0;
  assign mi_len    = in_cmd ? own_len  : '0;
  assign mi_rw     = in_cmd & own_rw;
  assign req_ready = (mi_valid & mi_ready) ? grant : '0;

  // Memctrl strobes only reach the owner, and only while a burst is in flight.
  assign mi_wdata  = in_data ? own_wdata : '0;
  assign req_rdata = in_data ? mi_rdata  : '0;
  assign req_wack  = (in_data & mi_wack)  ? grant : '0;
  assign req_wlast = (in_data & mi_wlast) ? grant : '0;
  assign req_rstb  = (in_data & mi_rstb)  ? grant : '0;
  assign req_rlast = (in_data & mi_rlast) ? grant : '0;

  assign burst_end = in_data & (rw_q ? (mi_rstb & mi_rlast) : (mi_wack & mi_wlast));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      last_win <= {1'b1, {(N_REQ-1){1'b0}}};
      rw_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            grant <= win;
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!own_valid) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (mi_ready) begin
            rw_q  <= own_rw;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (burst_end) begin
            last_win <= grant;
            grant    <= '0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
